led_blinker: RTL and testbench
==============================

LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4096: clock cycles per blink tick, ≥2.
REQ-002 SHALL have parameter ON_TICKS, default 2: ticks LED is lit per blink, ≥1.
REQ-003 SHALL have parameter OFF_TICKS, default 2: ticks LED is dark between blinks, ≥1.
REQ-004 SHALL have parameter GAP_TICKS, default 6: dark ticks after the last blink before returning idle, ≥1.
REQ-005 SHALL have port clock, input, 1: the single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port req, input, 1: one-cycle request to start a blink sequence (e.g. driven by a debounced key event).
REQ-008 SHALL have port code, input, 3: blink count minus one, so 0..7 gives 1..8 blinks; sampled with req.
REQ-009 SHALL have port steady_on, input, 1: LED level while idle.
REQ-010 SHALL have port led, output, 1: registered LED drive.
REQ-011 SHALL have port busy, output, 1: high while a sequence is in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on sequence completion.

Function
REQ-013 SHALL implement FSM states IDLE, ON, OFF, GAP.
REQ-014 IDLE: led SHALL follow steady_on with one register of delay; busy=0.
REQ-015 req=1 in IDLE SHALL latch remaining=code+1 (4-bit), clear the prescaler, and enter ON on the next edge; led=1 and busy=1 from that edge.
REQ-016 req while busy SHALL be ignored; no queuing, and latched code SHALL be unchanged.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle at TICK_DIV-1, then wrap to 0.
REQ-018 Phase length SHALL be exactly ON_TICKS*TICK_DIV cycles for ON, OFF_TICKS*TICK_DIV for OFF, and GAP_TICKS*TICK_DIV for GAP; a phase tick counter SHALL clear on every state change.
REQ-019 ON expiry SHALL enter OFF with led=0 and decrement remaining.
REQ-020 OFF expiry SHALL enter ON if remaining≠0, otherwise GAP; led=0 in OFF and GAP.
REQ-021 GAP expiry SHALL enter IDLE; done=1 for that single cycle, busy=0 in the same cycle, and led=steady_on on the next edge.
REQ-022 req coinciding with the GAP-to-IDLE cycle SHALL be ignored; it is accepted only while state==IDLE.
REQ-023 Total busy duration SHALL be ((code+1)*(ON_TICKS+OFF_TICKS)+GAP_TICKS)*TICK_DIV cycles.
REQ-024 steady_on changes during a sequence SHALL NOT affect led until IDLE.

Reset
REQ-025 Asserting reset at any time, including mid-sequence, SHALL immediately force state=IDLE, led=0, busy=0, done=0, prescaler=0, phase counter=0, remaining=0.
REQ-026 After reset deasserts, led SHALL take steady_on on the first clock edge; no done pulse SHALL be produced for an aborted sequence.

Structure
REQ-027 Package led_blinker_pkg SHALL hold the state enum, the code width (3), and the remaining-counter width (4).
REQ-028 The prescaler SHALL be a sub-module tick_gen (params DIV; ports clock, reset, clear, tick).

Verification (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3)
REQ-029 Hold steady_on=1, reset, then release -> led=0 during reset, led=1 one edge after release, busy=0.
REQ-030 req with code=2 in IDLE -> led pattern 8 high / 4 low repeated 3 times, then 12 low; busy high 48 cycles; done pulses once at cycle 48.
REQ-031 req with code=0 -> exactly one blink (8 high / 4 low), then 12 gap, busy 24 cycles.
REQ-032 Second req 5 cycles after first (code=7) -> ignored; the sequence keeps the original code=2 length of 48 cycles.
REQ-033 Reset at cycle 20 of a code=2 sequence -> led=0, busy=0 immediately; no done pulse; the next req starts a fresh full sequence.
REQ-034 req on the done cycle -> ignored; req one cycle later is accepted.

Source files
------------

// File: rtl/led_blinker_pkg.sv
// Shared widths and FSM state encoding for the LED blink-code sequencer.
package led_blinker_pkg;

   localparam int CODE_W = 3;
   localparam int REM_W  = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t ON   = 2'd1;
   localparam state_t OFF  = 2'd2;
   localparam state_t GAP  = 2'd3;

endpackage

// File: rtl/led_blinker_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, restartable via clear.
module tick_gen #(
   parameter int DIV = 4096
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/led_blinker.sv
// Blinks an LED code+1 times per request, then holds a dark gap before idling
// on the steady_on level.
module led_blinker
   import led_blinker_pkg::*;
#(
   parameter int TICK_DIV  = 4096,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 2,
   parameter int GAP_TICKS = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic [CODE_W-1:0] code,
   input  logic              steady_on,
   output logic              led,
   output logic              busy,
   output logic              done
);

   localparam int MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_T = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
   localparam int PH_W  = $clog2(MAX_T + 1);

   localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
   localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
   localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

   state_t           state;
   logic [REM_W-1:0] remaining;
   logic [PH_W-1:0]  phase;
   logic             tick;
   logic             start;
   logic             phase_end;

   // The done cycle already shows state==IDLE; a request there must still be dropped.
   assign start = (state == IDLE) && req && !done;

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clock (clock),
      .reset (reset),
      .clear (start),
      .tick  (tick)
   );

   always_comb begin
      phase_end = 1'b0;
      case (state)
         ON:      phase_end = tick && (phase == ON_LAST);
         OFF:     phase_end = tick && (phase == OFF_LAST);
         GAP:     phase_end = tick && (phase == GAP_LAST);
         default: phase_end = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         led       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         phase     <= '0;
      end else begin
         done <= 1'b0;
         if (phase_end) begin
            phase <= '0;
         end else if (tick && state != IDLE) begin
            phase <= phase + PH_W'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= ON;
                  led       <= 1'b1;
                  busy      <= 1'b1;
                  remaining <= REM_W'(code) + REM_W'(1);
                  phase     <= '0;
               end else begin
                  led  <= steady_on;
                  busy <= 1'b0;
               end
            end
            ON: begin
               if (phase_end) begin
                  state     <= OFF;
                  led       <= 1'b0;
                  remaining <= remaining - REM_W'(1);
               end
            end
            OFF: begin
               if (phase_end) begin
                  if (remaining != '0) begin
                     state <= ON;
                     led   <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (phase_end) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  led   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               led   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with a per-cycle expected-output scoreboard.
module tb_led_blinker;

   localparam int TICK_DIV  = 4;
   localparam int ON_TICKS  = 2;
   localparam int OFF_TICKS = 1;
   localparam int GAP_TICKS = 3;
   localparam int ON_CYC    = ON_TICKS * TICK_DIV;
   localparam int OFF_CYC   = OFF_TICKS * TICK_DIV;
   localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;

   typedef struct {
      logic  led;
      logic  busy;
      logic  done;
      string tag;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic [2:0] code = 3'd0;
   logic       steady_on = 1'b1;
   logic       led;
   logic       busy;
   logic       done;

   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   exp_t sb[$];

   led_blinker #(
      .TICK_DIV  (TICK_DIV),
      .ON_TICKS  (ON_TICKS),
      .OFF_TICKS (OFF_TICKS),
      .GAP_TICKS (GAP_TICKS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .code      (code),
      .steady_on (steady_on),
      .led       (led),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic got, input logic want);
      checks++;
      assert (got === want) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, got, want);
      end
   endtask

   task automatic push(input logic l, input logic b, input logic d, input string tag);
      exp_t e;
      e.led  = l;
      e.busy = b;
      e.done = d;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Expected outputs for every cycle after the accepting edge, through the done cycle.
   task automatic push_seq(input int c, input string name);
      int n = 0;
      for (int b = 0; b <= c; b++) begin
         for (int i = 0; i < ON_CYC; i++) begin
            push(1'b1, 1'b1, 1'b0, $sformatf("%s[%0d]", name, n)); n++;
         end
         for (int i = 0; i < OFF_CYC; i++) begin
            push(1'b0, 1'b1, 1'b0, $sformatf("%s[%0d]", name, n)); n++;
         end
      end
      for (int i = 0; i < GAP_CYC; i++) begin
         push(1'b0, 1'b1, 1'b0, $sformatf("%s[%0d]", name, n)); n++;
      end
      push(1'b0, 1'b0, 1'b1, $sformatf("%s_done[%0d]", name, n));
   endtask

   task automatic push_idle(input logic s, input int count, input string name);
      for (int i = 0; i < count; i++) push(s, 1'b0, 1'b0, $sformatf("%s[%0d]", name, i));
   endtask

   task automatic step();
      exp_t e;
      @(posedge clock);
      #1;
      req = 1'b0;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({e.tag, ".led"}, led, e.led);
         check({e.tag, ".busy"}, busy, e.busy);
         check({e.tag, ".done"}, done, e.done);
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_req(input int c, input string name);
      req  = 1'b1;
      code = 3'(c);
      push_seq(c, name);
   endtask

   initial begin
      // Power-on reset with steady_on high
      #12;
      check("rst.led", led, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      push_idle(1'b1, 3, "rel");
      steps(3);

      // Idle follows steady_on with one register of delay
      steady_on = 1'b0;
      push_idle(1'b0, 2, "idle0");
      steps(2);
      steady_on = 1'b1;
      push_idle(1'b1, 2, "idle1");
      steps(2);

      // code=2, steady_on toggled mid-sequence
      start_req(2, "c2");
      push_idle(1'b1, 2, "c2_after");
      for (int i = 0; i < 51; i++) begin
         if (i == 10) steady_on = 1'b0;
         if (i == 40) steady_on = 1'b1;
         step();
      end

      // code=0 ending in idle-dark
      steady_on = 1'b0;
      start_req(0, "c0");
      push_idle(1'b0, 2, "c0_after");
      steps(27);

      // Second req while busy is dropped
      steady_on = 1'b1;
      start_req(2, "ign");
      steps(5);
      req  = 1'b1;
      code = 3'd7;
      push_idle(1'b1, 2, "ign_after");
      steps(46);

      // req on done cycle ignored, one cycle later accepted
      start_req(0, "dn");
      steps(25);
      req  = 1'b1;
      code = 3'd1;
      push_idle(1'b1, 1, "dn_ign");
      step();
      start_req(0, "dn2");
      push_idle(1'b1, 1, "dn2_after");
      steps(26);

      // Reset mid-sequence aborts without done
      start_req(2, "ab");
      steps(20);
      sb.delete();
      reset = 1'b1;
      #1;
      check("ab_rst.led", led, 1'b0);
      check("ab_rst.busy", busy, 1'b0);
      check("ab_rst.done", done, 1'b0);
      @(posedge clock);
      #1;
      check("ab_hold.led", led, 1'b0);
      check("ab_hold.busy", busy, 1'b0);
      reset = 1'b0;
      push_idle(1'b1, 40, "ab_idle");
      steps(40);

      // Fresh full sequence after the abort
      start_req(2, "fresh");
      push_idle(1'b1, 1, "fresh_after");
      steps(50);

      check("sb_empty", sb.size() == 0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
